pe_result_merger: RTL and testbench
===================================

PE_RESULT_MERGER -- requirements
Module: pe_result_merger

Interface
REQ-001: Parameter DATA_WIDTH, default 16, width of every data path.
REQ-002: clock  input  1  single clock; all state updates on rising edge.
REQ-003: reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-004: io_pe0_valid  input  1  PE0 result available.
REQ-005: io_pe0_ready  output  1  merger can accept a PE0 result.
REQ-006: io_pe0_data  input  DATA_WIDTH  PE0 result payload.
REQ-007: io_pe1_valid / io_pe1_ready / io_pe1_data: same directions, widths and meanings as the PE0 ports, for PE1.
REQ-008: io_out_valid  output  1  merged result presented downstream.
REQ-009: io_out_ready  input  1  downstream accepts result.
REQ-010: io_out_data  output  DATA_WIDTH  merged result payload.
REQ-011: io_out_src  output  1  originating PE of io_out_data (0 = PE0, 1 = PE1).
REQ-012: io_count  output  16  number of completed output transfers, modulo 2^16.

Function
REQ-013: Each PE input SHALL have a one-entry holding buffer (full flag, data); io_peN_ready SHALL equal NOT full_N, driven from a register only.
REQ-014: Input handshake: io_peN_valid AND io_peN_ready at a rising edge SHALL load io_peN_data into buffer N and set full_N.
REQ-015: An output register SHALL hold out_valid, out_data and out_src; io_out_* SHALL be driven directly from it.
REQ-016: The output register is "free" in a cycle when out_valid = 0 OR io_out_ready = 1.
REQ-017: When free and at least one buffer is full, the edge SHALL move exactly one buffer into the output register, clear that buffer's full flag, and set out_src to its index.
REQ-018: When free and no buffer is full, the edge SHALL clear out_valid (if a transfer completed) and leave out_data unchanged.
REQ-019: When not free, the output register and both buffers SHALL hold; io_out_data and io_out_src SHALL stay stable while io_out_valid = 1 AND io_out_ready = 0.
REQ-020: Arbitration: only one buffer full -> grant it; both full -> grant the index NOT equal to last_grant.
REQ-021: last_grant (1-bit register) SHALL update to the granted index on every move; reset value 1, so PE0 wins the first tie.
REQ-022: Latency: a result accepted at edge E SHALL appear with io_out_valid = 1 after edge E+1 at the earliest (2 cycles input-to-output).
REQ-023: Throughput: each input accepts at most one result per 2 cycles; aggregate output sustains one result per cycle while both PEs supply data and io_out_ready = 1.
REQ-024: A buffer SHALL NOT be loaded and drained on the same edge (ready is low while full).
REQ-025: io_count SHALL increment by 1 on every edge with io_out_valid AND io_out_ready, wrapping 0xFFFF -> 0x0000.
REQ-026: No result SHALL be dropped, duplicated or reordered within one PE's stream; ordering across PEs follows REQ-020.

Reset
REQ-027: Reset SHALL clear full_0, full_1, out_valid, out_src, out_data, io_count to 0 and set last_grant to 1.
REQ-028: While reset is high, io_pe0_ready = io_pe1_ready = 1 and io_out_valid = 0.
REQ-029: Reset asserted mid-operation SHALL discard all buffered and presented results; no transfer is reported after release until new input arrives.

Verification
REQ-030: Single result: PE0 sends 0x1234 at edge 1, io_out_ready = 1 -> io_out_valid = 1, data 0x1234, src 0 after edge 2; io_count = 1 after edge 3.
REQ-031: Simultaneous arrival: PE0 0xAAAA and PE1 0xBBBB at the same edge -> outputs 0xAAAA (src 0) then 0xBBBB (src 1) on consecutive cycles; next tie grants PE0 again.
REQ-032: Backpressure: io_out_ready = 0 for 10 cycles with both PEs streaming -> io_out stable, both ready low after buffers fill, no loss; release -> results drain alternating src 0/1.
REQ-033: Full-rate merge: both PEs continuously valid, io_out_ready = 1, 100 cycles -> output valid every cycle in steady state, per-PE order preserved, io_count matches transfer total.
REQ-034: Counter wrap: preload via 65536 transfers -> io_count reads 0x0000 after the 65536th transfer.
REQ-035: Reset mid-stream: assert reset with both buffers and output full -> io_out_valid = 0 and both ready = 1 immediately (before next edge); first post-reset output is the first post-reset input.

Source files
------------

// File: rtl/pe_result_merger.sv
// pe_result_merger: merges results from two processing elements into one
// downstream stream. Each PE feeds a one-entry holding buffer; a single
// output register presents one result at a time, with round-robin
// arbitration when both buffers hold data.
module pe_result_merger #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_pe0_valid,
    output logic                  io_pe0_ready,
    input  logic [DATA_WIDTH-1:0] io_pe0_data,
    input  logic                  io_pe1_valid,
    output logic                  io_pe1_ready,
    input  logic [DATA_WIDTH-1:0] io_pe1_data,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [DATA_WIDTH-1:0] io_out_data,
    output logic                  io_out_src,
    output logic [15:0]           io_count
);

    localparam int unsigned CNT_W = 16;

    logic                  r_full0;
    logic                  r_full1;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_src;
    logic                  r_last_grant;
    logic [CNT_W-1:0]      r_count;

    logic w_free;
    logic w_move;
    logic w_grant;
    logic w_load0;
    logic w_load1;
    logic w_done;

    // Handshake decode and round-robin grant selection
    always_comb begin
        w_free  = ~r_out_valid | io_out_ready;
        w_move  = w_free & (r_full0 | r_full1);
        w_load0 = io_pe0_valid & ~r_full0;
        w_load1 = io_pe1_valid & ~r_full1;
        w_done  = r_out_valid & io_out_ready;
        if (r_full0 && r_full1) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = r_full1;
        end
    end

    // PE0 holding buffer: load only while empty, drain only while full
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_full0 <= 1'b0;
            r_buf0  <= '0;
        end else if (w_load0) begin
            r_full0 <= 1'b1;
            r_buf0  <= io_pe0_data;
        end else if (w_move && !w_grant) begin
            r_full0 <= 1'b0;
        end
    end

    // PE1 holding buffer: load only while empty, drain only while full
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_full1 <= 1'b0;
            r_buf1  <= '0;
        end else if (w_load1) begin
            r_full1 <= 1'b1;
            r_buf1  <= io_pe1_data;
        end else if (w_move && w_grant) begin
            r_full1 <= 1'b0;
        end
    end

    // Output register; data and source hold while stalled or idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_move) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_grant ? r_buf1 : r_buf0;
            r_out_src    <= w_grant;
            r_last_grant <= w_grant;
        end else if (w_free) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Completed-transfer counter, wraps naturally at 2^16
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_done) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign io_pe0_ready = ~r_full0;
    assign io_pe1_ready = ~r_full1;
    assign io_out_valid = r_out_valid;
    assign io_out_data  = r_out_data;
    assign io_out_src   = r_out_src;
    assign io_count     = r_count;

endmodule

// File: tb/tb_pe_result_merger.sv
// Directed testbench for pe_result_merger with a per-PE ordering scoreboard.
module tb_pe_result_merger;

    localparam int unsigned DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          pe0_valid, pe1_valid, out_ready;
    logic [DW-1:0] pe0_data, pe1_data;
    logic          pe0_ready, pe1_ready, out_valid, out_src;
    logic [DW-1:0] out_data;
    logic [15:0]   count;

    pe_result_merger #(.DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_pe0_valid (pe0_valid),
        .io_pe0_ready (pe0_ready),
        .io_pe0_data  (pe0_data),
        .io_pe1_valid (pe1_valid),
        .io_pe1_ready (pe1_ready),
        .io_pe1_data  (pe1_data),
        .io_out_valid (out_valid),
        .io_out_ready (out_ready),
        .io_out_data  (out_data),
        .io_out_src   (out_src),
        .io_count     (count)
    );

    always #5 clock = ~clock;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            xfers   = 0;
    logic          en0 = 1'b0, en1 = 1'b0;
    logic [DW-1:0] nxt0, nxt1;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          exp_src_en = 1'b0;
    logic          exp_src    = 1'b0;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One streaming cycle: record accepts, score transfers, advance stimulus
    task automatic cyc();
        logic          a0, a1, t, os;
        logic [DW-1:0] od, e;
        a0 = pe0_valid && pe0_ready;
        a1 = pe1_valid && pe1_ready;
        t  = out_valid && out_ready;
        od = out_data;
        os = out_src;
        tick();
        if (a0) begin q0.push_back(pe0_data); nxt0 = nxt0 + DW'(1); end
        if (a1) begin q1.push_back(pe1_data); nxt1 = nxt1 + DW'(1); end
        if (t) begin
            xfers++;
            if (exp_src_en) begin
                check("alt_src", 32'(os), 32'(exp_src));
                exp_src = ~exp_src;
            end
            if (!os) begin
                check("sb_q0_nonempty", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin e = q0.pop_front(); check("sb_data0", 32'(od), 32'(e)); end
            end else begin
                check("sb_q1_nonempty", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin e = q1.pop_front(); check("sb_data1", 32'(od), 32'(e)); end
            end
        end
        pe0_valid = en0;
        pe0_data  = nxt0;
        pe1_valid = en1;
        pe1_data  = nxt1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pe0_valid = 1'b0;
        pe1_valid = 1'b0;
        en0       = 1'b0;
        en1       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        xfers      = 0;
        exp_src_en = 1'b0;
        exp_src    = 1'b0;
    endtask

    task automatic drain();
        en0 = 1'b0; en1 = 1'b0;
        pe0_valid = 1'b0; pe1_valid = 1'b0;
        exp_src_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) cyc();
        check("drain_q0_empty", 32'(q0.size()), 32'd0);
        check("drain_q1_empty", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; pe0_valid = 1'b0; pe1_valid = 1'b0; out_ready = 1'b0;
        pe0_data = '0; pe1_data = '0; nxt0 = '0; nxt1 = '0;
        tick();
        check("rst_ready0", 32'(pe0_ready), 32'd1);
        check("rst_ready1", 32'(pe1_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        do_reset();

        // Single result latency
        out_ready = 1'b1;
        pe0_valid = 1'b1; pe0_data = 16'h1234;
        tick();
        pe0_valid = 1'b0;
        check("single_full_ready0", 32'(pe0_ready), 32'd0);
        check("single_e1_valid", 32'(out_valid), 32'd0);
        tick();
        check("single_e2_valid", 32'(out_valid), 32'd1);
        check("single_e2_data", 32'(out_data), 32'h1234);
        check("single_e2_src", 32'(out_src), 32'd0);
        check("single_e2_count", 32'(count), 32'd0);
        tick();
        check("single_e3_count", 32'(count), 32'd1);
        check("single_e3_valid", 32'(out_valid), 32'd0);
        check("single_e3_data_hold", 32'(out_data), 32'h1234);

        // Simultaneous arrival, then a second tie
        do_reset();
        out_ready = 1'b1;
        pe0_valid = 1'b1; pe0_data = 16'hAAAA;
        pe1_valid = 1'b1; pe1_data = 16'hBBBB;
        tick();
        pe0_valid = 1'b0; pe1_valid = 1'b0;
        check("tie_ready0", 32'(pe0_ready), 32'd0);
        check("tie_ready1", 32'(pe1_ready), 32'd0);
        tick();
        check("tie1_data", 32'(out_data), 32'hAAAA);
        check("tie1_src", 32'(out_src), 32'd0);
        tick();
        check("tie2_data", 32'(out_data), 32'hBBBB);
        check("tie2_src", 32'(out_src), 32'd1);
        pe0_valid = 1'b1; pe0_data = 16'hCCCC;
        pe1_valid = 1'b1; pe1_data = 16'hDDDD;
        tick();
        pe0_valid = 1'b0; pe1_valid = 1'b0;
        check("tie_gap_valid", 32'(out_valid), 32'd0);
        check("tie_gap_count", 32'(count), 32'd2);
        tick();
        check("tie3_data", 32'(out_data), 32'hCCCC);
        check("tie3_src", 32'(out_src), 32'd0);
        tick();
        check("tie4_data", 32'(out_data), 32'hDDDD);
        check("tie4_src", 32'(out_src), 32'd1);
        tick();
        check("tie_count", 32'(count), 32'd4);

        // Backpressure for 10 cycles with both PEs streaming
        do_reset();
        out_ready = 1'b0;
        nxt0 = 16'h0100; nxt1 = 16'h0200;
        en0 = 1'b1; en1 = 1'b1;
        pe0_valid = 1'b1; pe0_data = nxt0;
        pe1_valid = 1'b1; pe1_data = nxt1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i >= 3) begin
                check("bp_valid", 32'(out_valid), 32'd1);
                check("bp_data", 32'(out_data), 32'h0100);
                check("bp_src", 32'(out_src), 32'd0);
                check("bp_ready0", 32'(pe0_ready), 32'd0);
                check("bp_ready1", 32'(pe1_ready), 32'd0);
            end
        end
        check("bp_count", 32'(count), 32'd0);
        out_ready  = 1'b1;
        exp_src_en = 1'b1;
        exp_src    = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        drain();

        // Full-rate merge for 100 cycles
        do_reset();
        out_ready = 1'b1;
        nxt0 = 16'h0000; nxt1 = 16'h8000;
        en0 = 1'b1; en1 = 1'b1;
        pe0_valid = 1'b1; pe0_data = nxt0;
        pe1_valid = 1'b1; pe1_data = nxt1;
        exp_src_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            cyc();
            if (k >= 2) check("fr_valid", 32'(out_valid), 32'd1);
        end
        check("fr_count_const", 32'(count), 32'd98);
        check("fr_count_xfers", 32'(count), 32'(xfers));
        drain();

        // Counter wrap after 65536 transfers
        do_reset();
        out_ready = 1'b1;
        nxt0 = 16'h0000; nxt1 = 16'h8000;
        en0 = 1'b1; en1 = 1'b1;
        pe0_valid = 1'b1; pe0_data = nxt0;
        pe1_valid = 1'b1; pe1_data = nxt1;
        exp_src_en = 1'b1;
        for (int k = 1; k <= 65538; k++) begin
            cyc();
            if (k == 65537) check("wrap_ffff", 32'(count), 32'h0000_FFFF);
            if (k == 65538) check("wrap_zero", 32'(count), 32'h0000_0000);
        end

        // Reset in the middle of a stalled stream
        do_reset();
        out_ready = 1'b0;
        nxt0 = 16'h0300; nxt1 = 16'h0400;
        en0 = 1'b1; en1 = 1'b1;
        pe0_valid = 1'b1; pe0_data = nxt0;
        pe1_valid = 1'b1; pe1_data = nxt1;
        for (int i = 0; i < 4; i++) cyc();
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        check("mid_pre_ready0", 32'(pe0_ready), 32'd0);
        check("mid_pre_ready1", 32'(pe1_ready), 32'd0);
        reset = 1'b1;
        pe0_valid = 1'b0; pe1_valid = 1'b0;
        en0 = 1'b0; en1 = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready0", 32'(pe0_ready), 32'd1);
        check("mid_rst_ready1", 32'(pe1_ready), 32'd1);
        tick();
        reset = 1'b0;
        q0.delete(); q1.delete();
        xfers = 0;
        exp_src_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        check("mid_idle_valid", 32'(out_valid), 32'd0);
        check("mid_idle_count", 32'(count), 32'd0);
        nxt1 = 16'hCAFE;
        pe1_valid = 1'b1; pe1_data = nxt1;
        cyc();
        check("mid_new_e1_valid", 32'(out_valid), 32'd0);
        cyc();
        check("mid_new_valid", 32'(out_valid), 32'd1);
        check("mid_new_data", 32'(out_data), 32'hCAFE);
        check("mid_new_src", 32'(out_src), 32'd1);
        cyc();
        check("mid_new_count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
